// File: rtl/output_overlap_add_if.sv
// Stream bundle for output_overlap_add: the input sample stream and the tagged output stream.
// The master modport is the overlap-add block's view; slave is the surrounding environment.
interface output_overlap_add_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12
);
  logic                      s_axis_tvalid;
  logic [DATA_WIDTH-1:0]     s_axis_tdata;
  logic                      s_axis_tready;
  logic                      m_axis_tvalid;
  logic [DATA_WIDTH-1:0]     m_axis_tdata;
  logic                      m_axis_final_cnt;
  logic [FFT_SIZE_WIDTH-2:0] phase;
  logic                      m_axis_tready;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_final_cnt, phase
  );
  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_final_cnt, phase
  );
endinterface

// File: rtl/output_overlap_add.sv
// Overlap-add of M-sample frames into M/2 outputs: out[k] = x[k] + x[k+M/2], via a read-first RAM and skid FIFO.
// Macro OLA_SATURATE_EN: defined -> saturate each I/Q sum to 16 bits; undefined -> halve each sum (floor).
module output_overlap_add #(
  parameter int DATA_WIDTH      = 32,
  parameter int FFT_SIZE_WIDTH  = 12,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  output_overlap_add_if.master      bus
);
  localparam int AW         = FFT_SIZE_WIDTH - 2;
  localparam int PW         = FFT_SIZE_WIDTH - 1;
  localparam int HW         = DATA_WIDTH / 2;
  localparam int FPW        = FIFO_DEPTH_LOG2;
  localparam int FCW        = FIFO_DEPTH_LOG2 + 1;
  localparam int CW         = FIFO_DEPTH_LOG2 + 2;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AF_LEVEL   = FIFO_DEPTH - 6;
  localparam int EW         = DATA_WIDTH + PW + 1;

  typedef enum logic {S_FIRST, S_SECOND} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   half_m_q, half_m_d;
  logic            s_ready, in_xfer, cnt_last, almost_full;
  logic [CW-1:0]   occupancy;

  logic [DATA_WIDTH-1:0] ram [2**AW];
  logic [DATA_WIDTH-1:0] ram_rd_q, ram_rd2_q, ram_rd3_q;

  logic [2:0]            pv_q, pfin_q;
  logic [DATA_WIDTH-1:0] pd_q  [3];
  logic [PW-1:0]         pph_q [3];

  logic [DATA_WIDTH-1:0] sum_d, sum_q;
  logic [PW-1:0]         sum_ph_q;
  logic                  sum_v_q, sum_fin_q;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]  fifo_cnt_q;
  logic            push, pop;

  logic                  out_v_q, out_fin_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [PW-1:0]         out_ph_q;

  // Every sample that can still become an output counts against the FIFO headroom.
  assign occupancy = CW'(fifo_cnt_q) + CW'(out_v_q) + CW'(pv_q[0]) + CW'(pv_q[1])
                   + CW'(pv_q[2]) + CW'(sum_v_q);
  assign almost_full = (occupancy >= CW'(AF_LEVEL));
  assign cnt_last    = (PW'(cnt_q) == half_m_q - PW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_m_d = half_m_q;
    s_ready  = !sync_reset && ((state_q == S_FIRST) || !almost_full);
    in_xfer  = bus.s_axis_tvalid && s_ready;
    if (state_q == S_FIRST && cnt_q == '0)
      half_m_d = PW'(fft_size >> 1);
    if (in_xfer) begin
      if (cnt_last) begin
        cnt_d   = '0;
        state_d = (state_q == S_FIRST) ? S_SECOND : S_FIRST;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= S_FIRST;
      cnt_q    <= '0;
      half_m_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_m_q <= half_m_d;
    end
  end

  assign bus.s_axis_tready = s_ready;

  // Read-first port: a first-half write may hit the address read by the previous frame's last sample.
  always_ff @(posedge clk) begin
    if (in_xfer && state_q == S_FIRST)
      ram[cnt_q] <= bus.s_axis_tdata;
    ram_rd_q  <= ram[cnt_q];
    ram_rd2_q <= ram_rd_q;
    ram_rd3_q <= ram_rd2_q;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pv_q <= '0;
    end else begin
      pv_q <= {pv_q[1:0], in_xfer && (state_q == S_SECOND)};
    end
    pfin_q   <= {pfin_q[1:0], cnt_last};
    pd_q[0]  <= bus.s_axis_tdata;
    pph_q[0] <= PW'(cnt_q);
    for (int i = 1; i < 3; i++) begin
      pd_q[i]  <= pd_q[i-1];
      pph_q[i] <= pph_q[i-1];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic signed [HW:0] lane_sum;
    assign lane_sum = {ram_rd3_q[gi*HW+HW-1], ram_rd3_q[gi*HW +: HW]}
                    + {pd_q[2][gi*HW+HW-1], pd_q[2][gi*HW +: HW]};
`ifdef OLA_SATURATE_EN
    assign sum_d[gi*HW +: HW] = (lane_sum[HW] != lane_sum[HW-1])
                              ? {lane_sum[HW], {(HW-1){~lane_sum[HW]}}}
                              : lane_sum[HW-1:0];
`else
    assign sum_d[gi*HW +: HW] = HW'(lane_sum >>> 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (sync_reset) sum_v_q <= 1'b0;
    else            sum_v_q <= pv_q[2];
    sum_q     <= sum_d;
    sum_ph_q  <= pph_q[2];
    sum_fin_q <= pfin_q[2];
  end

  assign push = sum_v_q;
  assign pop  = (fifo_cnt_q != '0) && (!out_v_q || bus.m_axis_tready);

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {sum_fin_q, sum_ph_q, sum_q};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_v_q    <= 1'b0;
      out_fin_q  <= 1'b0;
      out_ph_q   <= '0;
      out_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FPW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FPW'(1);
      fifo_cnt_q <= fifo_cnt_q + FCW'(push) - FCW'(pop);
      // Output register only reloads once its current word is taken, keeping it stable under backpressure.
      if (pop) begin
        out_v_q <= 1'b1;
        {out_fin_q, out_ph_q, out_data_q} <= fifo_mem[rd_ptr_q];
      end else if (bus.m_axis_tready) begin
        out_v_q <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tvalid    = out_v_q;
  assign bus.m_axis_tdata     = out_data_q;
  assign bus.m_axis_final_cnt = out_fin_q;
  assign bus.phase            = out_ph_q;
endmodule

// File: doc/output_overlap_add.md
Name: output_overlap_add

Overview:
- Synthesis-side counterpart of the M/2 channelizer input buffer. It accepts frames of M = fft_size complex samples from the synthesis FFT and emits M/2 samples per frame, where out[k] = x[k] + x[k+M/2] for k = 0..M/2-1.
- The first half of each frame is held in a single read-first block RAM with 3-cycle latency. Second-half samples are summed against the stored values on the fly.
- Output passes through a small skid FIFO. The FIFO's almost-full flag throttles input acceptance.

Parameters:
- DATA_WIDTH, 32: complex sample width, I in [31:16], Q in [15:0], two's complement.
- FFT_SIZE_WIDTH, 12: width of fft_size. RAM address width is FFT_SIZE_WIDTH-2.
- FIFO_DEPTH_LOG2, 4: output skid FIFO depth of 16.

Ports:
- clk  in  1  clock
- sync_reset  in  1  synchronous, active-high reset
- fft_size  in  FFT_SIZE_WIDTH  M, a power of 2 from 8 to 2^(FFT_SIZE_WIDTH-1); sampled at frame start only
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  DATA_WIDTH  input sample
- s_axis_tready  out  1  input accept
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  DATA_WIDTH  overlap-added sample
- m_axis_final_cnt  out  1  high on the last output sample, k = M/2-1
- phase  out  FFT_SIZE_WIDTH-1  output index k
- m_axis_tready  in  1  downstream accept

Behaviour:
- Reset: a synchronous, active-high reset on sync_reset, sampled at the clk edge. Reset values:
  - s_axis_tready=0 for the reset cycle, 1 after it.
  - m_axis_tvalid=0, m_axis_final_cnt=0, phase=0, m_axis_tdata=0.
  - FIFO emptied, state=S_FIRST, counter=0.
  - Reset mid-frame discards the partial frame and all FIFO contents. RAM contents are not cleared.
- Transfer: a sample moves when s_axis_tvalid && s_axis_tready. Same rule for the master side.
- half_m is registered as fft_size>>1 and latched when the counter is 0 in S_FIRST. A change to fft_size mid-frame is ignored.
- State S_FIRST:
  - Each input transfer writes the RAM at addr=cnt.
  - At cnt == half_m-1: cnt goes to 0, next state is S_SECOND.
- State S_SECOND:
  - Each input transfer issues a RAM read at addr=cnt.
  - The input sample is delayed 3 cycles to align with RAM data. The sum is registered one cycle later, then pushed to the FIFO.
  - Accept-to-FIFO-write latency is 4 cycles. FIFO-write-to-m_axis_tvalid latency is 1 cycle.
  - At cnt == half_m-1: cnt goes to 0, next state is S_FIRST.
- Read-first RAM: a next-frame first-half write may follow the same-address read back-to-back without hazard.
- Arithmetic: I and Q are added independently in 17 bits. See the optional feature for reduction to 16 bits.
- Tags: phase = k and final_cnt = (k == half_m-1) are carried through the pipeline alongside the data.
- Flow control: s_axis_tready = ~almost_full, where almost_full = FIFO occupancy + in-flight pipeline entries >= FIFO depth - 6.
  - s_axis_tready is also 1 in S_FIRST when the FIFO is full; S_FIRST writes produce no output.
- No output is ever dropped. No FIFO overflow is allowed; the bench checks for it with an assertion.
- FIFO empty: m_axis_tvalid=0. m_axis_tdata holds its last value.
- Simultaneous FIFO push and pop when full: only possible when a pop frees an entry, so it is legal.
- m_axis_tdata, m_axis_final_cnt and phase must be held stable while m_axis_tvalid && !m_axis_tready.

Optional Feature:
- Macro: OLA_SATURATE_EN.
- Defined: each 17-bit I/Q sum is saturated to 16 bits, range -32768..32767. Gain is unity.
- Undefined: each 17-bit sum is arithmetic-shifted right by 1, truncating toward -inf. Gain is 1/2 and overflow cannot occur.
- Pipeline latency is identical in both builds.

Test Plan:
- M=8, input x[n]=n in both I and Q, m_axis_tready=1 -> outputs I=Q of {4,6,8,10} (saturate build) or {2,3,4,5} (shift build). phase is 0..3, final_cnt only on phase 3.
- M=16, I=0x7FFF for all samples -> saturate build gives 0x7FFF ×8. Shift build gives 0x7FFF ×8.
- M=8, I=0x8000 for all samples -> saturate build gives 0x8000. Shift build gives 0x8000. Q=0x0001 with x[k+4].Q=0xFFFF gives Q=0 in both builds.
- Continuous 1000 random frames with M=64 and m_axis_tready held low 70% of cycles at random -> output matches the golden model exactly, with no lost or duplicated samples and no FIFO overflow.
- fft_size switched from 16 to 32 mid-frame -> the current frame completes with M=16, and the next frame uses M=32 (16 outputs).
- sync_reset asserted for 1 cycle after 5 samples of an M=8 frame -> m_axis_tvalid=0 on the next cycle, and the next 8 inputs form a fresh frame with correct sums.
